// File: rtl/packed_array_assembler.sv
// ---------------------------------------------------------------------------
// packed_array_assembler
//
// Collects a serial stream of ELEM_W-bit elements into a packed word
// logic [NUM_ELEM-1:0][ELEM_W-1:0]. The first element of each word lands at
// the top index, so a consumer walking foreach(word[i]) from NUM_ELEM-1 down
// to 0 sees the elements in arrival order. One completed word is buffered on
// the output side. Both sides use valid/ready handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the partial word (highest priority after
//              reset); a completed word waiting on the output is kept
//   in_valid   producer presents in_elem
//   in_ready   assembler accepts an element this cycle (combinational)
//   in_elem    element value, sampled only on an input transfer
//   out_valid  out_word holds a complete word
//   out_ready  consumer takes out_word this cycle
//   out_word   packed word, element k at bits [k*ELEM_W +: ELEM_W]
//   fill_cnt   elements held in the partial word (0..NUM_ELEM-1)
// ---------------------------------------------------------------------------
module packed_array_assembler #(
  parameter int NUM_ELEM = 3,
  parameter int ELEM_W   = 4,
  localparam int CNT_W   = $clog2(NUM_ELEM + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELEM_W-1:0]          in_elem,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_ELEM*ELEM_W-1:0] out_word,
  output logic [CNT_W-1:0]           fill_cnt
);

  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ELEM - 1);

  typedef logic [NUM_ELEM-1:0][ELEM_W-1:0] word_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t state;
  word_t  shadow;
  word_t  word_q;
  logic   in_fire;
  logic   out_fire;

  // Writes elem into the slot for the pos-th arrival of a word. The n-th
  // arrival goes to index NUM_ELEM-1-n so arrival order reads top-down.
  function automatic word_t place(input word_t          word,
                                  input logic [CNT_W-1:0] pos,
                                  input logic [ELEM_W-1:0] elem);
    word_t           w;
    logic [CNT_W-1:0] slot;
    w    = word;
    slot = LAST_CNT - pos;
    w[IDX_W'(slot)] = elem;
    return w;
  endfunction

  // Handshake decode. in_ready also opens in FULL when the buffered word is
  // leaving this cycle, which lets the next word start without a bubble.
  assign out_fire = out_valid & out_ready;
  assign in_ready = (state == FILL) | out_fire;
  assign in_fire  = in_valid & in_ready;

  assign out_word = word_q;

  // Assembly and output buffer stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      word_q    <= '0;
      shadow    <= '0;
    end else if (clear) begin
      // The partial word and any element offered this cycle are discarded.
      // A completed word is untouched but may still be consumed normally.
      fill_cnt <= '0;
      shadow   <= '0;
      if ((state == FULL) && out_fire) begin
        out_valid <= 1'b0;
        state     <= FILL;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            if (fill_cnt == LAST_CNT) begin
              word_q    <= place(shadow, fill_cnt, in_elem);
              out_valid <= 1'b1;
              fill_cnt  <= '0;
              shadow    <= '0;
              state     <= FULL;
            end else begin
              shadow   <= place(shadow, fill_cnt, in_elem);
              fill_cnt <= fill_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            state     <= FILL;
            // Shadow is already zero here, so a simultaneous element simply
            // becomes the first arrival of the next word.
            if (in_valid) begin
              shadow   <= place('0, '0, in_elem);
              fill_cnt <= CNT_W'(1);
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule
